// File: rtl/storage_pkg.sv
// Shared types and sizing helpers for the front-panel shift bank.
package storage_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned STAGE_IDX_W             = 4;

  // Wide enough to address any stage of the largest (16-stage) bank
  typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned sel_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/storage_shift_bank_button_edge.sv
// Raw button -> one-cycle press pulse: 2-FF synchroniser, optional debounce
// (STORAGE_SHIFT_BANK_DEBOUNCE_EN), arming after a confirmed low, rising-edge detect.
module button_edge
  import storage_pkg::*;
`ifdef STORAGE_SHIFT_BANK_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pulse_c
);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       level;
  logic       level_q;
  logic       armed_q;

  // fill_q marks when the synchroniser holds real samples rather than reset zeros
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], button};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

`ifdef STORAGE_SHIFT_BANK_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt_q;
  logic             db_level_q;

  // Debounced level follows the synchronised one only after a full stable run
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (sync_q[1] == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q   <= '0;
      db_level_q <= sync_q[1];
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  assign level = db_level_q;
`else
  assign level = sync_q[1];
`endif

  // Arm only on a genuinely sampled low so a press held through reset is ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level;
      armed_q <= armed_q | (fill_q[1] & ~sync_q[1] & ~level);
    end
  end

  assign pulse_c = level & ~level_q & armed_q;

endmodule

// File: rtl/storage_shift_bank.sv
// DEPTH-stage, WIDTH-bit front-panel shift bank with write/transfer/clear buttons.
// Optional button debounce: define STORAGE_SHIFT_BANK_DEBOUNCE_EN.
module storage_shift_bank
  import storage_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              switches,
  input  logic                          write_button,
  input  logic                          transfer_button,
  input  logic                          clear_button,
  input  logic                          rotate_mode,
  input  logic [sel_width(DEPTH)-1:0]   view_sel,
  output logic [WIDTH-1:0]              head_leds,
  output logic [WIDTH-1:0]              tail_leds,
  output logic [WIDTH-1:0]              view_leds,
  output logic [DEPTH-1:0]              valid,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);

  localparam int unsigned SEL_W = sel_width(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);
  localparam int unsigned N_BTN = 3;

  if (DEPTH < 2 || DEPTH > 16 || DEBOUNCE_CYCLES == 0) begin : g_bad_param
    $error("storage_shift_bank: DEPTH must be 2..16 and DEBOUNCE_CYCLES nonzero");
  end

  logic [N_BTN-1:0] raw_buttons;
  logic [N_BTN-1:0] pulses;
  logic             write_pulse;
  logic             transfer_pulse;
  logic             clear_pulse;

  assign raw_buttons = {clear_button, transfer_button, write_button};

  for (genvar b = 0; b < int'(N_BTN); b++) begin : g_btn
`ifdef STORAGE_SHIFT_BANK_DEBOUNCE_EN
    button_edge #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_edge (
      .clk     (clk),
      .reset   (reset),
      .button  (raw_buttons[b]),
      .pulse_c (pulses[b])
    );
`else
    button_edge u_button_edge (
      .clk     (clk),
      .reset   (reset),
      .button  (raw_buttons[b]),
      .pulse_c (pulses[b])
    );
`endif
  end

  assign write_pulse    = pulses[0];
  assign transfer_pulse = pulses[1];
  assign clear_pulse    = pulses[2];

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins; otherwise transfer is applied first and a write then owns stage 0
  always_comb begin
    stage_d    = stage_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (clear_pulse) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] = '0;
      end
      valid_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (transfer_pulse) begin
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_d[i] = stage_q[i-1];
        end
        valid_d = {valid_q[DEPTH-2:0], 1'b0};
        if (rotate_mode) begin
          stage_d[0] = stage_q[DEPTH-1];
          valid_d[0] = valid_q[DEPTH-1];
        end else begin
          stage_d[0] = '0;
          overflow_d = overflow_q | valid_q[DEPTH-1];
        end
      end
      if (write_pulse) begin
        // A rotated tail displaced by the write is lost data
        if (transfer_pulse && rotate_mode) begin
          overflow_d = overflow_q | valid_q[DEPTH-1];
        end
        stage_d[0] = switches;
        valid_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      valid_q    <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      stage_q    <= stage_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  stage_idx_t view_idx;
  assign view_idx = stage_idx_t'(view_sel);

  // Out-of-range selections fall through to zero
  always_comb begin
    view_leds = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (view_idx == stage_idx_t'(i)) begin
        view_leds = stage_q[i];
      end
    end
  end

  assign head_leds = stage_q[0];
  assign tail_leds = stage_q[DEPTH-1];
  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

  logic unused_sel_w;
  assign unused_sel_w = ^SEL_W;

endmodule

// File: tb/tb_storage_shift_bank.sv
// Scoreboard bench for storage_shift_bank: queue-based reference model, decoupled monitor.
module tb_storage_shift_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] switches = '0;
  logic             write_button = 1'b0;
  logic             transfer_button = 1'b0;
  logic             clear_button = 1'b0;
  logic             rotate_mode = 1'b0;
  logic [1:0]       view_sel = '0;
  logic [WIDTH-1:0] head_leds;
  logic [WIDTH-1:0] tail_leds;
  logic [WIDTH-1:0] view_leds;
  logic [DEPTH-1:0] valid;
  logic [2:0]       count;
  logic             overflow;

  storage_shift_bank #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .switches        (switches),
    .write_button    (write_button),
    .transfer_button (transfer_button),
    .clear_button    (clear_button),
    .rotate_mode     (rotate_mode),
    .view_sel        (view_sel),
    .head_leds       (head_leds),
    .tail_leds       (tail_leds),
    .view_leds       (view_leds),
    .valid           (valid),
    .count           (count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] head;
    logic [7:0] tail;
    logic [7:0] view;
    logic [3:0] vld;
    logic [2:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the bank as an ordered list, index 0 = head
  logic [7:0] m_data[$];
  logic       m_valid[$];
  logic       m_ovf;

  function automatic void model_reset();
    m_data  = {8'h00, 8'h00, 8'h00, 8'h00};
    m_valid = {1'b0, 1'b0, 1'b0, 1'b0};
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_apply(input logic w, input logic t, input logic c,
                                      input logic [7:0] sw, input logic rot);
    logic [7:0] d;
    logic       v;
    if (c) begin
      model_reset();
      return;
    end
    v = 1'b0;
    if (t) begin
      d = m_data.pop_back();
      v = m_valid.pop_back();
      if (rot) begin
        m_data.push_front(d);
        m_valid.push_front(v);
      end else begin
        m_data.push_front(8'h00);
        m_valid.push_front(1'b0);
        if (v) m_ovf = 1'b1;
      end
    end
    if (w) begin
      if (t && rot && v) m_ovf = 1'b1;
      m_data[0]  = sw;
      m_valid[0] = 1'b1;
    end
  endfunction

  function automatic exp_t snapshot(input int due, input logic [1:0] vs);
    exp_t e;
    int   n;
    n      = 0;
    e.due  = due;
    e.head = m_data[0];
    e.tail = m_data[DEPTH-1];
    e.view = m_data[vs];
    for (int i = 0; i < int'(DEPTH); i++) begin
      e.vld[i] = m_valid[i];
      if (m_valid[i]) n++;
    end
    e.cnt = 3'(n);
    e.ovf = m_ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against every expectation due this cycle
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        check("missed_sample", 32'(cyc), 32'(e.due));
      end else begin
        check("head_leds", 32'(head_leds), 32'(e.head));
        check("tail_leds", 32'(tail_leds), 32'(e.tail));
        check("view_leds", 32'(view_leds), 32'(e.view));
        check("valid",     32'(valid),     32'(e.vld));
        check("count",     32'(count),     32'(e.cnt));
        check("overflow",  32'(overflow),  32'(e.ovf));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    sb.push_back(snapshot(cyc + 1, view_sel));
    repeat (4) @(negedge clk);
  endtask

  // Press a button combination; the bank changes three edges after the drive
  task automatic op(input logic w, input logic t, input logic c, input logic [7:0] sw,
                    input logic rot, input logic [1:0] vs, input int hold);
    int n;
    @(negedge clk);
    switches        = sw;
    rotate_mode     = rot;
    view_sel        = vs;
    write_button    = w;
    transfer_button = t;
    clear_button    = c;
    n = cyc;
    model_apply(w, t, c, sw, rot);
    sb.push_back(snapshot(n + 3, vs));
    if (hold > 10) begin
      sb.push_back(snapshot(n + hold - 2, vs));
      sb.push_back(snapshot(n + hold + 3, vs));
    end
    repeat (hold) @(negedge clk);
    write_button    = 1'b0;
    transfer_button = 1'b0;
    clear_button    = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic held_through_reset();
    @(negedge clk);
    reset        = 1'b0;
    switches     = 8'hEE;
    write_button = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    sb.push_back(snapshot(cyc + 3, view_sel));
    sb.push_back(snapshot(cyc + 12, view_sel));
    repeat (15) @(negedge clk);
    write_button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    op(1, 0, 0, 8'hA5, 0, 0, 20);

    do_reset();
    op(1, 0, 0, 8'h11, 0, 0, 4);
    op(0, 1, 0, 8'h00, 0, 0, 4);
    op(1, 0, 0, 8'h22, 0, 1, 4);
    op(0, 1, 0, 8'h00, 0, 1, 4);
    op(1, 0, 0, 8'h33, 0, 2, 4);

    op(0, 1, 0, 8'h00, 0, 3, 4);
    op(1, 0, 0, 8'h44, 0, 3, 4);
    op(0, 1, 0, 8'h00, 0, 3, 4);
    op(1, 0, 1, 8'h99, 0, 0, 4);

    do_reset();
    op(1, 0, 0, 8'h01, 0, 0, 4);
    op(0, 1, 0, 8'h00, 0, 0, 4);
    op(1, 0, 0, 8'h02, 0, 0, 4);
    op(0, 1, 0, 8'h00, 0, 0, 4);
    op(1, 0, 0, 8'h03, 0, 0, 4);
    op(0, 1, 0, 8'h00, 0, 0, 4);
    op(1, 0, 0, 8'h04, 0, 0, 4);
    op(0, 1, 0, 8'h00, 1, 3, 4);

    op(1, 1, 0, 8'h5A, 0, 1, 4);
    op(1, 1, 0, 8'h6B, 1, 2, 4);

    held_through_reset();
    op(1, 0, 0, 8'h3C, 0, 0, 4);

    for (int k = 0; k < 80; k++) begin
      logic w, t, c;
      w = 1'($urandom % 2);
      t = 1'($urandom % 2);
      c = ($urandom % 10) == 0;
      if (!w && !t && !c) w = 1'b1;
      op(w, t, c, 8'($urandom), 1'($urandom % 2), 2'($urandom % 4), 4);
    end

    repeat (10) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("unchecked_expectation", 32'(cyc), 32'(e.due));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
